// File: rtl/if_stage_if.sv
// Fetch-stage bundle: decode handshake, redirect bus and instruction SRAM port.
// master = fetch stage side, slave = decode/SRAM environment side.
interface if_stage_if;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic        inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  modport master (
    input  ds_allowin,
    input  br_bus,
    input  inst_sram_rdata,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output inst_sram_en,
    output inst_sram_we,
    output inst_sram_addr,
    output inst_sram_wdata
  );

  modport slave (
    output ds_allowin,
    output br_bus,
    output inst_sram_rdata,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  inst_sram_en,
    input  inst_sram_we,
    input  inst_sram_addr,
    input  inst_sram_wdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: pre-IF address generation plus registered IF stage
// with a one-entry buffer that holds SRAM data across decode stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.master fs
);

  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;
  logic        buf_load;

  logic        fs_valid_q;
  logic        fs_valid_d;
  logic [31:0] fs_pc_q;
  logic [31:0] fs_pc_d;
  logic        buf_valid_q;
  logic        buf_valid_d;
  logic [31:0] inst_buf_q;
  logic [31:0] inst_buf_d;

  // pre-IF: address generation
  always_comb begin
    br_taken    = fs.br_bus[32];
    br_target   = fs.br_bus[31:0];
    to_fs_valid = ~reset;
    fs_ready_go = 1'b1;
    seq_pc      = fs_pc_q + 32'd4;
    nextpc      = br_taken ? br_target : seq_pc;
    fs_allowin  = ~fs_valid_q | fs.ds_allowin | br_taken;
  end

  // IF: next-state for valid, pc and the stall buffer
  always_comb begin
    fs_valid_d  = fs_valid_q;
    fs_pc_d     = fs_pc_q;
    buf_valid_d = buf_valid_q;
    inst_buf_d  = inst_buf_q;
    buf_load    = fs_valid_q & ~fs.ds_allowin
                & ~br_taken & ~buf_valid_q;
    if (fs_allowin) begin
      fs_valid_d  = to_fs_valid;
      buf_valid_d = 1'b0;
      if (to_fs_valid) begin
        fs_pc_d = nextpc;
      end
    end else if (buf_load) begin
      // SRAM data is only valid the cycle after the request
      buf_valid_d = 1'b1;
      inst_buf_d  = fs.inst_sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fs_valid_q  <= 1'b0;
      fs_pc_q     <= RESET_PC - 32'd4;
      buf_valid_q <= 1'b0;
      inst_buf_q  <= 32'h0;
    end else begin
      fs_valid_q  <= fs_valid_d;
      fs_pc_q     <= fs_pc_d;
      buf_valid_q <= buf_valid_d;
      inst_buf_q  <= inst_buf_d;
    end
  end

  always_comb begin
    fs_inst = buf_valid_q ? inst_buf_q
                          : fs.inst_sram_rdata;
  end

  // wrong-path instruction dropped in the redirect cycle
  assign fs.fs_to_ds_valid  = fs_valid_q & fs_ready_go & ~br_taken;
  assign fs.fs_to_ds_bus    = {fs_pc_q, fs_inst};
  assign fs.inst_sram_en    = to_fs_valid & fs_allowin;
  assign fs.inst_sram_we    = 1'b0;
  assign fs.inst_sram_addr  = nextpc;
  assign fs.inst_sram_wdata = 32'h0;

endmodule
